mem_line_arbiter: RTL

Two-master arbiter that shares the single 256-bit line memory port (addr/data/we/rd/ack) between the instruction-cache refill path (master 0) and the data-cache refill/writeback path (master 1). Sits between the CPU's cache controllers and the external memory controller. Serialises line transactions, round-robin on contention, and returns read lines and acks to the winning master only. Exactly one memory transaction is outstanding at a time.

---
 rtl/mem_line_arbiter_pkg.sv | 21 ++
 rtl/mem_line_arbiter_rr.sv | 26 ++
 rtl/mem_line_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_line_arbiter_pkg.sv
// Shared definitions for the line-memory arbiter and the cache controllers
// that sit in front of it.
//   state_t           : arbiter FSM encoding (IDLE / BUSY / DONE)
//   MASTER_ICACHE/DCACHE : master index constants used for grant / last_grant
//   *_DEF             : default widths shared with the cache controllers
package mem_line_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MASTER_ICACHE = 1'b0;  // master 0: instruction-cache refill
  localparam logic MASTER_DCACHE = 1'b1;  // master 1: data-cache refill/writeback

  localparam int ADDR_WIDTH_DEF  = 32;
  localparam int LINE_WIDTH_DEF  = 256;
  localparam int OFFSET_BITS_DEF = 5;

endpackage

// File: rtl/mem_line_arbiter_rr.sv
// Combinational two-way round-robin pick.
//   req[1:0]   : per-master request levels
//   last_grant : master served by the most recent completed transaction
//   valid      : at least one request present
//   grant      : chosen master; on contention the one that was not served last
module mem_line_arbiter_rr
  import mem_line_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       grant
);

  always_comb begin
    valid = |req;
    grant = MASTER_ICACHE;
    case (req)
      2'b01:   grant = MASTER_ICACHE;
      2'b10:   grant = MASTER_DCACHE;
      2'b11:   grant = ~last_grant;
      default: grant = MASTER_ICACHE;
    endcase
  end

endmodule

// File: rtl/mem_line_arbiter.sv
// Two-master arbiter for the single 256-bit line memory port.
// Master 0 is the I-cache refill path, master 1 the D-cache refill/writeback
// path. One memory transaction is outstanding at a time.
//
// Handshake: a master raises we and/or rd (level) with addr/data stable and
// holds them until its ack pulses for one cycle; it must drop the request in
// the ack cycle. Toward memory, mem_we_o/mem_rd_o are levels held with stable
// addr/data until mem_ack_i is sampled high on a posedge; mem_data_i is only
// looked at in that cycle, and only for reads.
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   mN_addr_i/mN_data_i     : master N line address / write line
//   mN_we_i/mN_rd_i         : master N write / read request levels
//   mN_data_o/mN_ack_o      : read line returned / completion pulse to master N
//   mem_addr_o/mem_data_o   : line address (offset bits zero) / write line
//   mem_we_o/mem_rd_o       : memory strobes
//   mem_data_i/mem_ack_i    : memory read line / completion
//   dbg_state               : current FSM state for observation
module mem_line_arbiter
  import mem_line_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int LINE_WIDTH  = LINE_WIDTH_DEF,
  parameter int OFFSET_BITS = OFFSET_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [LINE_WIDTH-1:0] m0_data_i,
  input  logic                  m0_we_i,
  input  logic                  m0_rd_i,
  output logic [LINE_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [LINE_WIDTH-1:0] m1_data_i,
  input  logic                  m1_we_i,
  input  logic                  m1_rd_i,
  output logic [LINE_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [LINE_WIDTH-1:0] mem_data_o,
  output logic                  mem_we_o,
  output logic                  mem_rd_o,
  input  logic [LINE_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack_i,
  output logic [1:0]            dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  state_t state, state_next;
  logic   grant, last_grant;
  logic   pick_valid, pick;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LINE_WIDTH-1:0] sel_data;
  logic                  sel_we, sel_rd;

  mem_line_arbiter_rr u_rr (
    .req        ({m1_we_i | m1_rd_i, m0_we_i | m0_rd_i}),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .grant      (pick)
  );

  always_comb begin
    sel_addr = (pick == MASTER_DCACHE) ? m1_addr_i : m0_addr_i;
    sel_data = (pick == MASTER_DCACHE) ? m1_data_i : m0_data_i;
    sel_we   = (pick == MASTER_DCACHE) ? m1_we_i   : m0_we_i;
    sel_rd   = (pick == MASTER_DCACHE) ? m1_rd_i   : m0_rd_i;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (pick_valid) state_next = ST_BUSY;
      ST_BUSY: if (mem_ack_i)  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath. Requests are sampled only on the granting edge; everything
  // presented to memory is frozen from then until mem_ack_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_o <= '0;
      mem_data_o <= '0;
      mem_we_o   <= 1'b0;
      mem_rd_o   <= 1'b0;
      m0_ack_o   <= 1'b0;
      m1_ack_o   <= 1'b0;
      m0_data_o  <= '0;
      m1_data_o  <= '0;
      grant      <= MASTER_ICACHE;
      last_grant <= MASTER_DCACHE;  // so master 0 wins the first tie
    end else begin
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant      <= pick;
            mem_addr_o <= sel_addr & LINE_MASK;
            mem_data_o <= sel_data;
            mem_we_o   <= sel_we;
            mem_rd_o   <= sel_rd & ~sel_we;  // write wins over a simultaneous read
          end
        end
        ST_BUSY: begin
          if (mem_ack_i) begin
            mem_we_o   <= 1'b0;
            mem_rd_o   <= 1'b0;
            last_grant <= grant;
            if (grant == MASTER_ICACHE) begin
              m0_ack_o <= 1'b1;
              if (mem_rd_o) m0_data_o <= mem_data_i;
            end else begin
              m1_ack_o <= 1'b1;
              if (mem_rd_o) m1_data_o <= mem_data_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state;

endmodule
